// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard receiver feeding a first-word-fall-through scan-code FIFO.
// It synchronises the PS/2 lines and decodes 11-bit frames: start, 8 data
// bits LSB first, odd parity, stop. Good bytes go into the FIFO. Bad frames
// and stalled frames raise frame_err. With BREAK_TAG=1, an 0xF0 prefix is
// folded into bit 8 of the byte that follows it.
module ps2_key_fifo #(
    parameter  int DEPTH          = 16,
    parameter  int SYNC_STAGES    = 2,
    parameter  int TIMEOUT_CYCLES = 50000,
    parameter  int BREAK_TAG      = 0,
    localparam int W              = 8 + BREAK_TAG,
    localparam int CW             = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          frame_err,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s, ps2_data_s, fe;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pending_q, pending_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;

    logic          push, tag, pop, wr_en;
    logic [W-1:0]  push_data;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fe         = clk_prev_q & ~ps2_clk_s;

    // Synchronisers and edge-detect history; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q  <= ps2_clk_s;
        end
    end

    // Frame decoder state, timeout counter, break flag and event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            pending_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            pending_q   <= pending_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic for the receiver. A timeout takes priority over a
    // falling edge. Any error drops a pending break prefix.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        parity_d    = parity_q;
        tmo_d       = '0;
        pending_d   = pending_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        tag         = (BREAK_TAG != 0) && pending_q && (shift_q != 8'hE0);
        push_data   = W'(shift_q) | (W'(tag) << 8);

        if (!fe && state_q != IDLE) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (!fe && state_q != IDLE && tmo_q == TMO_LAST) begin
            state_d     = IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
            pending_d   = 1'b0;
        end else if (fe) begin
            case (state_q)
                IDLE: begin
                    if (!ps2_data_s) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        pending_d   = 1'b0;
                    end
                end
                DATA: begin
                    shift_d  = {ps2_data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = ps2_data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (ps2_data_s && (^{shift_q, parity_q})) begin
                        if (BREAK_TAG != 0 && shift_q == 8'hF0) begin
                            pending_d = 1'b1;
                        end else begin
                            push = 1'b1;
                            if (shift_q != 8'hE0) begin
                                pending_d = 1'b0;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        pending_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping: pop first, so a full FIFO accepts a push in the same
    // cycle as a pop. The registered head is refreshed to whatever is at the
    // front afterwards, or holds its value when the FIFO drains.
    always_comb begin
        pop        = rd_en && (count_q != '0);
        wr_en      = push && ((count_q != DEPTH_C) || pop);
        overflow_d = push && (count_q == DEPTH_C) && !pop;
        count_d    = count_q + CW'(wr_en) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        rd_data_d  = rd_data_q;
        if (count_d != '0) begin
            if (count_q == '0 || (count_q == CW'(1) && pop)) begin
                rd_data_d = push_data;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Bench for ps2_key_fifo. Two instances share the PS/2 lines: one plain and
// one with break tagging. Each has a queue-based reference model.
module tb_ps2_key_fifo;

    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, rd_en;
    logic [7:0] rd0;
    logic [8:0] rd1;
    logic       empty0, empty1, full0, full1, err0, err1, ovf0, ovf1;
    logic [2:0] count0, count1;

    int n_chk = 0, n_pass = 0;
    int q0[$], q1[$];
    int shown0, shown1, pend;
    int exp_err, exp_ovf0, exp_ovf1;
    int err_cnt0 = 0, err_cnt1 = 0, ovf_cnt0 = 0, ovf_cnt1 = 0;

    ps2_key_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO), .BREAK_TAG(0)) u0 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .rd_data(rd0), .empty(empty0), .full(full0), .count(count0),
        .frame_err(err0), .overflow(ovf0));

    ps2_key_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO), .BREAK_TAG(1)) u1 (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
        .rd_data(rd1), .empty(empty1), .full(full1), .count(count1),
        .frame_err(err1), .overflow(ovf1));

    always #5 clk = ~clk;

    // Pulse counters; a stuck or stretched pulse inflates the count.
    always @(negedge clk) begin
        if (err0) err_cnt0++;
        if (err1) err_cnt1++;
        if (ovf0) ovf_cnt0++;
        if (ovf1) ovf_cnt1++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        q0.delete(); q1.delete();
        shown0 = 0; shown1 = 0; pend = 0;
    endfunction

    function automatic void refresh_shown();
        if (q0.size() != 0) shown0 = q0[0];
        if (q1.size() != 0) shown1 = q1[0];
    endfunction

    function automatic void model_pop();
        if (q0.size() != 0) void'(q0.pop_front());
        if (q1.size() != 0) void'(q1.pop_front());
        refresh_shown();
    endfunction

    function automatic void model_err();
        exp_err++;
        pend = 0;
    endfunction

    // Receipt of a good byte, optionally with a same-cycle read.
    function automatic void model_byte(input int b, input bit rd_same);
        int v;
        if (rd_same && q0.size() != 0) void'(q0.pop_front());
        if (q0.size() < DEPTH) q0.push_back(b); else exp_ovf0++;
        if (rd_same && q1.size() != 0) void'(q1.pop_front());
        if (b == 8'hF0) begin
            pend = 1;
        end else begin
            v = b + ((pend != 0 && b != 8'hE0) ? 256 : 0);
            if (b != 8'hE0) pend = 0;
            if (q1.size() < DEPTH) q1.push_back(v); else exp_ovf1++;
        end
        refresh_shown();
    endfunction

    // Drive nbits PS/2 bits LSB first. After the last falling edge, count
    // cycles until count0 moves. Optionally pulse rd_en so that it lands in
    // the same clock as the push.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit rd_stop,
                             output int lat);
        logic [2:0] c0;
        lat = -1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == nbits - 1) begin
                c0 = count0;
                for (int k = 1; k <= 8; k++) begin
                    @(negedge clk);
                    if (k == SS && rd_stop) rd_en = 1'b1;
                    if (k == SS + 1) rd_en = 1'b0;
                    if (lat < 0 && count0 != c0) lat = k;
                end
            end else begin
                repeat (8) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit rd_stop, output int lat);
        logic par, stp;
        par = (~^b) ^ bad_par;
        stp = ~bad_stop;
        send_bits({stp, par, b, 1'b0}, 11, rd_stop, lat);
        if (!bad_par && !bad_stop) model_byte(int'(b), rd_stop);
        else begin
            model_err();
            if (rd_stop) model_pop();
        end
    endtask

    task automatic pop_one();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
        model_pop();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count0"}, 32'(count0), 32'(q0.size()));
        check({tag, ".empty0"}, 32'(empty0), 32'(q0.size() == 0));
        check({tag, ".full0"},  32'(full0),  32'(q0.size() == DEPTH));
        check({tag, ".rd0"},    32'(rd0),    32'(shown0));
        check({tag, ".count1"}, 32'(count1), 32'(q1.size()));
        check({tag, ".rd1"},    32'(rd1),    32'(shown1));
        check({tag, ".err0"},   32'(err_cnt0), 32'(exp_err));
        check({tag, ".err1"},   32'(err_cnt1), 32'(exp_err));
        check({tag, ".ovf0"},   32'(ovf_cnt0), 32'(exp_ovf0));
        check({tag, ".ovf1"},   32'(ovf_cnt1), 32'(exp_ovf1));
    endtask

    initial begin
        int lat, kind;
        logic [7:0] b;
        reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        exp_err = 0; exp_ovf0 = 0; exp_ovf1 = 0;
        model_reset();
        repeat (5) @(negedge clk);
        check_state("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single good frame; the push shows one cycle after the detected edge.
        send_frame(8'h1C, 0, 0, 0, lat);
        check("latency", 32'(lat), 32'(SS + 1));
        check("first_byte", 32'(rd0), 32'h1C);
        check_state("good");
        pop_one();
        check_state("pop");

        // Bad parity, then bad stop bit.
        send_frame(8'h1C, 1, 0, 0, lat);
        check_state("badpar");
        send_frame(8'h32, 0, 1, 0, lat);
        check_state("badstop");

        // Overfill, then drain in order.
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h10 + 8'(i), 0, 0, 0, lat);
            check_state("fill");
        end
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(rd0), 32'h10 + 32'(i));
            pop_one();
            check_state("drain");
        end

        // Full FIFO with a read landing in the push cycle.
        for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i), 0, 0, 0, lat);
        check_state("refill");
        send_frame(8'h55, 0, 0, 1, lat);
        check_state("push_pop_full");
        for (int i = 0; i < 4; i++) pop_one();
        check("last_read", 32'(rd0), 32'h55);
        check_state("drain2");

        // Break tagging.
        send_frame(8'hF0, 0, 0, 0, lat);
        send_frame(8'h1C, 0, 0, 0, lat);
        send_frame(8'hE0, 0, 0, 0, lat);
        send_frame(8'h75, 0, 0, 0, lat);
        check("brk_count", 32'(count1), 32'd3);
        check("brk_head0", 32'(rd1), 32'h11C);
        pop_one();
        check("brk_head1", 32'(rd1), 32'h0E0);
        pop_one();
        check("brk_head2", 32'(rd1), 32'h075);
        check_state("brk");
        while (q0.size() != 0) pop_one();

        // Stall after four data bits, then a clean frame.
        send_bits({4'b0000, 4'b1010, 1'b0}, 5, 0, lat);
        repeat (TMO + 20) @(negedge clk);
        model_err();
        check_state("timeout");
        send_frame(8'h29, 0, 0, 0, lat);
        check("after_tmo", 32'(rd0), 32'h29);
        check_state("after_tmo");

        // A falling edge while idle with data high is a bad start.
        send_bits(11'h7FF, 1, 0, lat);
        model_err();
        check_state("badstart");

        // Reset in the middle of a frame with data queued.
        send_frame(8'h66, 0, 0, 0, lat);
        send_bits({7'h00, 4'b0110}, 4, 0, lat);
        @(negedge clk) reset = 1'b0;
        #1;
        model_reset();
        check_state("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h3A, 0, 0, 0, lat);
        check_state("post_reset");

        // Random traffic.
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0, 1:    b = 8'hF0;
                2:       b = 8'hE0;
                default: b = 8'($urandom);
            endcase
            send_frame(b, kind == 6, kind == 7, 1'($urandom_range(0, 1)), lat);
            check_state("rand");
            repeat ($urandom_range(0, 2)) begin
                pop_one();
                check_state("rand_pop");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_key_fifo.md
PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops on ps2_clk and ps2_data (>=2).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning clk cycles without a ps2_clk falling edge that abort a frame.
REQ-004 The block SHALL have parameter BREAK_TAG, default 0, meaning 1 enables break-code tagging mode; W = 8+BREAK_TAG.
REQ-005 The block SHALL have port clk, input, 1, the system clock; every flop is clocked on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-007 The block SHALL have port ps2_clk, input, 1, the asynchronous keyboard clock.
REQ-008 The block SHALL have port ps2_data, input, 1, the asynchronous keyboard data.
REQ-009 The block SHALL have port rd_en, input, 1, pop request for the head entry.
REQ-010 The block SHALL have port rd_data, output, W, the head entry (first-word fall-through).
REQ-011 The block SHALL have port empty, output, 1, high when count == 0.
REQ-012 The block SHALL have port full, output, 1, high when count == DEPTH.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1), the number of stored entries.
REQ-014 The block SHALL have port frame_err, output, 1, a one-cycle pulse on a bad start, parity or stop bit, or on timeout.
REQ-015 The block SHALL have port overflow, output, 1, a one-cycle pulse when a completed byte is dropped because the FIFO is full.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through SYNC_STAGES flops; a falling edge (fe) SHALL be the synced clock at 1 in the previous cycle and 0 in the current cycle.
REQ-017 The receiver FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL sample synced ps2_data only on fe.
REQ-018 In IDLE on fe: data 0 SHALL go to DATA with bit counter 0; data 1 SHALL stay in IDLE and pulse frame_err.
REQ-019 DATA SHALL shift bits in LSB first and go to PARITY after the 8th bit.
REQ-020 PARITY SHALL capture the parity bit and go to STOP.
REQ-021 On fe in STOP, the frame SHALL be valid iff the stop bit is 1 and the 8 data bits plus parity have an odd number of ones; the FSM SHALL return to IDLE in all cases.
REQ-022 A valid frame SHALL be pushed so that rd_data, empty and count reflect it in the cycle after the stop-bit fe; an invalid frame SHALL be discarded and frame_err pulsed in that cycle.
REQ-023 A timeout counter SHALL clear on every fe and count while the FSM is not IDLE; at TIMEOUT_CYCLES the FSM SHALL go to IDLE, discard the partial byte and pulse frame_err.
REQ-024 With BREAK_TAG=1, a valid 0xF0 SHALL NOT be pushed and SHALL set a pending flag; the next valid byte SHALL be pushed with bit 8 = 1 and the flag cleared.
REQ-025 With BREAK_TAG=1, 0xE0 SHALL be pushed normally with bit 8 = 0, and a frame error or timeout SHALL clear the pending flag.
REQ-026 With BREAK_TAG=0, all valid bytes including 0xF0 SHALL be pushed unchanged.
REQ-027 When not empty, rd_en SHALL pop the head, advancing rd_data in the next cycle; when empty, rd_en SHALL be ignored.
REQ-028 A push while full SHALL drop the byte and pulse overflow, with no state change.
REQ-029 A push and a pop in the same cycle while full SHALL both occur, leaving count unchanged and no overflow.
REQ-030 A push and a pop in the same cycle while empty SHALL perform the push only (count = 1).
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 When empty, rd_data SHALL hold its last value.

Reset
REQ-033 While reset = 0, FSM = IDLE, pointers = 0, count = 0, empty = 1, full = 0, rd_data = 0, frame_err = 0, overflow = 0, the timeout counter and pending flag SHALL be cleared, and the sync flops SHALL be set to 1 (idle bus).
REQ-034 Reset asserted mid-frame or mid-stream SHALL abandon the partial frame and flush the FIFO immediately; the first frame after release SHALL be received correctly.

Verification
REQ-035 Send frame 0x1C with parity 0 and stop 1 -> one cycle after the stop fe: empty = 0, count = 1, rd_data = 0x1C; rd_en pulse -> empty = 1.
REQ-036 Send 0x1C with parity bit 1 -> frame_err pulses once, count stays 0; send 0x32 with stop bit 0 -> frame_err pulses, nothing pushed.
REQ-037 DEPTH=4: send 5 valid bytes without reads -> full = 1 after the 4th, overflow pulses on the 5th; reads return bytes 1-4 in order.
REQ-038 DEPTH=4, full: send a 5th byte with rd_en high in the push cycle -> count stays 4, no overflow, and the new byte is read last.
REQ-039 BREAK_TAG=1: send F0, 1C, E0, 75 -> FIFO holds 0x11C, 0x0E0, 0x075; count = 3.
REQ-040 Stop toggling ps2_clk after 4 data bits for TIMEOUT_CYCLES -> frame_err pulses and FSM returns to IDLE; the next full frame 0x29 is received correctly.
